// File: rtl/lcd_refresh_scheduler.sv
// Shadow frame buffer and refresh scheduler for the HD44780 character path.
// Ports: clk/rst (async active-low); two write requesters req0_*/req1_*
// (valid/row/col/char in, ready out); lcd_busy in, lcd_trg out; read port
// rd_row/rd_col in, rd_data out; dirty and refresh_count status outputs.
module lcd_refresh_scheduler #(
   parameter  int ROWS        = 4,
   parameter  int COLS        = 16,
   parameter  int MIN_GAP     = 2500,
   parameter  int ACK_TIMEOUT = 4,
   localparam int RW          = $clog2(ROWS),
   localparam int CW          = $clog2(COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   input  logic [RW-1:0] req0_row,
   input  logic [CW-1:0] req0_col,
   input  logic [7:0]    req0_char,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [RW-1:0] req1_row,
   input  logic [CW-1:0] req1_col,
   input  logic [7:0]    req1_char,
   output logic          req1_ready,
   input  logic          lcd_busy,
   output logic          lcd_trg,
   input  logic [RW-1:0] rd_row,
   input  logic [CW-1:0] rd_col,
   output logic [7:0]    rd_data,
   output logic          dirty,
   output logic [7:0]    refresh_count
);

   localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
   localparam int KW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_ACK,
      S_DONE,
      S_GAP
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [RW-1:0] r_clr_row;
   logic [CW-1:0] r_clr_col;
   logic          r_prio;
   logic          r_trg;
   logic          w_trg_nxt;
   logic          r_dirty;
   logic          w_dirty_nxt;
   logic [KW-1:0] r_ack_cnt;
   logic [KW-1:0] w_ack_nxt;
   logic [GW-1:0] r_gap_cnt;
   logic [GW-1:0] w_gap_nxt;
   logic [7:0]    r_ref_cnt;
   logic [7:0]    w_ref_nxt;
   logic [7:0]    r_rd_data;
   logic [7:0]    r_buf [ROWS][COLS];

   logic          w_arb_en;
   logic          w_gnt0;
   logic          w_gnt1;
   logic          w_wr_en;
   logic          w_wr_ok;
   logic [RW-1:0] w_wr_row;
   logic [CW-1:0] w_wr_col;
   logic [7:0]    w_wr_char;
   logic          w_wr_row_ok;
   logic          w_wr_col_ok;
   logic          w_rd_row_ok;
   logic          w_rd_col_ok;
   logic          w_clr_last;

   // r_prio=0 favours req0 on a tie; flips toward the other side on grant
   assign w_arb_en  = (r_state != S_CLEAR);
   assign w_gnt0    = w_arb_en & req0_valid & (~req1_valid | ~r_prio);
   assign w_gnt1    = w_arb_en & req1_valid & (~req0_valid | r_prio);
   assign w_wr_en   = w_gnt0 | w_gnt1;
   assign w_wr_row  = w_gnt1 ? req1_row  : req0_row;
   assign w_wr_col  = w_gnt1 ? req1_col  : req0_col;
   assign w_wr_char = w_gnt1 ? req1_char : req0_char;
   assign w_wr_ok   = w_wr_en & w_wr_row_ok & w_wr_col_ok;

   // Power-of-two geometries cannot address outside the buffer
   generate
      if (ROWS == (1 << RW)) begin : g_row_full
         assign w_wr_row_ok = 1'b1;
         assign w_rd_row_ok = 1'b1;
      end else begin : g_row_part
         assign w_wr_row_ok = (w_wr_row < RW'(ROWS));
         assign w_rd_row_ok = (rd_row < RW'(ROWS));
      end
      if (COLS == (1 << CW)) begin : g_col_full
         assign w_wr_col_ok = 1'b1;
         assign w_rd_col_ok = 1'b1;
      end else begin : g_col_part
         assign w_wr_col_ok = (w_wr_col < CW'(COLS));
         assign w_rd_col_ok = (rd_col < CW'(COLS));
      end
   endgenerate

   assign w_clr_last = (r_clr_row == RW'(ROWS - 1)) &&
                       (r_clr_col == CW'(COLS - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_trg_nxt   = 1'b0;
      w_ack_nxt   = r_ack_cnt;
      w_gap_nxt   = r_gap_cnt;
      w_ref_nxt   = r_ref_cnt;
      w_dirty_nxt = r_dirty | w_wr_ok;
      // The trigger cycle hands the buffer to the driver; only a write
      // landing in that same cycle keeps it marked as changed.
      if (r_trg) begin
         w_dirty_nxt = w_wr_ok;
      end
      unique case (r_state)
         S_CLEAR: begin
            if (w_clr_last) begin
               w_dirty_nxt = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_IDLE: begin
            if (r_dirty && !lcd_busy) begin
               w_trg_nxt   = 1'b1;
               w_ack_nxt   = '0;
               w_state_nxt = S_ACK;
            end
         end
         S_ACK: begin
            if (lcd_busy) begin
               w_state_nxt = S_DONE;
            end else if (r_ack_cnt == KW'(ACK_TIMEOUT - 1)) begin
               w_dirty_nxt = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_ack_nxt = r_ack_cnt + 1'b1;
            end
         end
         S_DONE: begin
            if (!lcd_busy) begin
               w_ref_nxt = r_ref_cnt + 8'd1;
               if (MIN_GAP == 0) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_gap_nxt   = GW'(MIN_GAP);
                  w_state_nxt = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (r_gap_cnt <= GW'(1)) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_gap_nxt = r_gap_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_CLEAR;
         r_clr_row <= '0;
         r_clr_col <= '0;
         r_prio    <= 1'b0;
         r_trg     <= 1'b0;
         r_dirty   <= 1'b0;
         r_ack_cnt <= '0;
         r_gap_cnt <= '0;
         r_ref_cnt <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_trg     <= w_trg_nxt;
         r_dirty   <= w_dirty_nxt;
         r_ack_cnt <= w_ack_nxt;
         r_gap_cnt <= w_gap_nxt;
         r_ref_cnt <= w_ref_nxt;
         if (w_gnt0) begin
            r_prio <= 1'b1;
         end else if (w_gnt1) begin
            r_prio <= 1'b0;
         end
         if (r_state == S_CLEAR) begin
            if (r_clr_col == CW'(COLS - 1)) begin
               r_clr_col <= '0;
               r_clr_row <= r_clr_row + 1'b1;
            end else begin
               r_clr_col <= r_clr_col + 1'b1;
            end
         end
      end
   end

   // Storage is not reset; CLEAR initialises it
   always_ff @(posedge clk) begin
      if (r_state == S_CLEAR) begin
         r_buf[r_clr_row][r_clr_col] <= 8'h20;
      end else if (w_wr_ok) begin
         r_buf[w_wr_row][w_wr_col] <= w_wr_char;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_data <= 8'h00;
      end else if (w_rd_row_ok && w_rd_col_ok) begin
         r_rd_data <= r_buf[rd_row][rd_col];
      end else begin
         r_rd_data <= 8'h20;
      end
   end

   assign req0_ready    = w_gnt0;
   assign req1_ready    = w_gnt1;
   assign lcd_trg       = r_trg;
   assign rd_data       = r_rd_data;
   assign dirty         = r_dirty;
   assign refresh_count = r_ref_cnt;

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Directed bench for lcd_refresh_scheduler: table-driven arbitration
// vectors plus hand-written refresh, timeout and reset sequences.
module tb_lcd_refresh_scheduler;

   localparam int ROWS = 4;
   localparam int COLS = 16;
   localparam int GAP  = 12;
   localparam int ACKT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       v0, v1;
   logic [1:0] row0, row1;
   logic [3:0] col0, col1;
   logic [7:0] ch0, ch1;
   logic       r0, r1;
   logic       busy;
   logic       trg;
   logic [1:0] rd_row;
   logic [3:0] rd_col;
   logic [7:0] rd_data;
   logic       dirty;
   logic [7:0] rcnt;

   int total = 0;
   int bad   = 0;
   int n;
   int base;
   int seen0;

   int   trg_seen = 0;
   logic prev_trg = 1'b0;
   logic dbl      = 1'b0;

   typedef struct {
      logic v0;
      logic v1;
      logic r0;
      logic r1;
   } vec_t;

   vec_t vecs [10];

   lcd_refresh_scheduler #(
      .ROWS(ROWS), .COLS(COLS),
      .MIN_GAP(GAP), .ACK_TIMEOUT(ACKT)
   ) dut (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_row(row0), .req0_col(col0),
      .req0_char(ch0), .req0_ready(r0),
      .req1_valid(v1), .req1_row(row1), .req1_col(col1),
      .req1_char(ch1), .req1_ready(r1),
      .lcd_busy(busy), .lcd_trg(trg),
      .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
      .dirty(dirty), .refresh_count(rcnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (trg) trg_seen <= trg_seen + 1;
      if (trg && prev_trg) dbl <= 1'b1;
      prev_trg <= trg;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic wait_trg(input int lim, output int cnt);
      cnt = 0;
      while (!trg && cnt < lim) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b1};

      rst = 1'b0; busy = 1'b1;
      v0 = 1'b1; row0 = 2'd3; col0 = 4'd15; ch0 = 8'h5A;
      v1 = 1'b0; row1 = '0; col1 = '0; ch1 = '0;
      rd_row = '0; rd_col = '0;
      repeat (3) tick();
      chk("rst_ready0", r0, 0);
      chk("rst_trg", trg, 0);
      chk("rst_rd", rd_data, 8'h00);
      chk("rst_dirty", dirty, 0);
      chk("rst_count", rcnt, 0);

      // CLEAR length, observed through the held-off req0 grant
      rst = 1'b1;
      n = 0;
      while (!r0 && n < 200) begin
         tick();
         n++;
      end
      chk("clear_len", n, 64);
      chk("clear_dirty", dirty, 1);
      chk("clear_trg", trg, 0);
      tick();
      v0 = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            rd_row = 2'(r);
            rd_col = 4'(c);
            tick();
            chk("clear_rd", rd_data,
                (r == 3 && c == 15) ? 8'h5A : 8'h20);
         end
      end
      chk("busy_hold_trg", trg, 0);

      // first refresh: trigger one cycle after busy falls
      busy = 1'b0;
      #1;
      chk("trg_not_yet", trg, 0);
      tick();
      chk("trg_post_busy", trg, 1);
      busy = 1'b1;
      tick();
      chk("trg_one_cycle", trg, 0);
      chk("dirty_cleared", dirty, 0);
      repeat (3) tick();
      busy = 1'b0;
      tick();
      chk("count_1", rcnt, 1);
      repeat (20) tick();
      chk("idle_no_trg", trg, 0);

      // round-robin table, driver held busy so no refresh interferes
      busy = 1'b1;
      row0 = 2'd1; col0 = 4'd3; ch0 = 8'h41;
      row1 = 2'd2; col1 = 4'd5; ch1 = 8'h42;
      for (int i = 0; i < 10; i++) begin
         v0 = vecs[i].v0;
         v1 = vecs[i].v1;
         #1;
         chk($sformatf("arb%0d_r0", i), r0, vecs[i].r0);
         chk($sformatf("arb%0d_r1", i), r1, vecs[i].r1);
         tick();
      end
      v0 = 1'b0; v1 = 1'b0;
      rd_row = 2'd1; rd_col = 4'd3;
      tick();
      chk("rd_A", rd_data, 8'h41);
      rd_row = 2'd2; rd_col = 4'd5;
      tick();
      chk("rd_B", rd_data, 8'h42);

      // read-before-write at the same address
      rd_row = 2'd0; rd_col = 4'd0;
      v0 = 1'b1; row0 = 2'd0; col0 = 4'd0; ch0 = 8'h51;
      tick();
      v0 = 1'b0;
      chk("rbw_old", rd_data, 8'h20);
      tick();
      chk("rbw_new", rd_data, 8'h51);

      // write in the trigger cycle keeps dirty; gap then retrigger
      chk("pre_dirty", dirty, 1);
      busy = 1'b0;
      tick();
      chk("trg2", trg, 1);
      v0 = 1'b1; row0 = 2'd0; col0 = 4'd1; ch0 = 8'h57;
      busy = 1'b1;
      #1;
      chk("trg_cycle_gnt", r0, 1);
      tick();
      v0 = 1'b0;
      chk("dirty_kept", dirty, 1);
      chk("trg2_low", trg, 0);
      repeat (3) tick();
      busy = 1'b0;
      wait_trg(100, n);
      chk("gap_len", n, GAP + 2);
      chk("count_2", rcnt, 2);

      // ten writes while the driver is busy -> one extra refresh
      base = rcnt;
      busy = 1'b1;
      tick();
      chk("dirty_in_done", dirty, 0);
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) begin
            v0 = 1'b1; v1 = 1'b0;
            row0 = 2'(i % 4); col0 = 4'(i); ch0 = 8'(8'h30 + i);
         end else begin
            v0 = 1'b0; v1 = 1'b1;
            row1 = 2'(i % 4); col1 = 4'(i); ch1 = 8'(8'h30 + i);
         end
         tick();
      end
      v0 = 1'b0; v1 = 1'b0;
      chk("dirty_after_10", dirty, 1);
      rd_row = 2'd1; rd_col = 4'd1;
      tick();
      chk("rd_w1", rd_data, 8'h31);
      seen0 = trg_seen;
      busy = 1'b0;
      wait_trg(100, n);
      chk("extra_gap_len", n, GAP + 2);
      busy = 1'b1;
      tick();
      repeat (2) tick();
      busy = 1'b0;
      repeat (60) tick();
      chk("one_extra_trg", trg_seen - seen0, 1);
      chk("count_plus2", rcnt, base + 2);

      // ack timeout and retry
      v0 = 1'b1; row0 = 2'd3; col0 = 4'd0; ch0 = 8'h54;
      tick();
      v0 = 1'b0;
      tick();
      chk("to_trg", trg, 1);
      tick();
      chk("to_trg_low", trg, 0);
      chk("to_dirty_clr", dirty, 0);
      repeat (3) tick();
      chk("to_dirty_set", dirty, 1);
      chk("to_no_trg", trg, 0);
      tick();
      chk("to_retry", trg, 1);
      busy = 1'b1;
      tick();
      repeat (2) tick();
      busy = 1'b0;
      tick();
      chk("count_5", rcnt, 5);
      repeat (3) tick();

      // asynchronous reset in the middle of GAP
      v0 = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_ready", r0, 0);
      chk("mid_rst_trg", trg, 0);
      chk("mid_rst_rd", rd_data, 8'h00);
      chk("mid_rst_dirty", dirty, 0);
      chk("mid_rst_count", rcnt, 0);
      repeat (2) tick();
      rst = 1'b1;
      n = 0;
      while (!r0 && n < 200) begin
         tick();
         n++;
      end
      chk("reclear_len", n, 64);
      chk("reclear_count", rcnt, 0);
      v0 = 1'b0;
      tick();
      chk("trg_width", dbl, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lcd_refresh_scheduler.md
# lcd_refresh_scheduler

Owns the 4x16 character shadow frame buffer for the HD44780 display path. It arbitrates character writes from two client requesters (round-robin) and serves the LCD driver's character read port. It also schedules refreshes, pulsing the driver's trigger when the buffer is dirty and the driver is idle, with a rate limit between refreshes.

## Interface
Parameters:
- ROWS, 4, display lines; row address width RW = $clog2(ROWS)
- COLS, 16, characters per line; column address width CW = $clog2(COLS)
- MIN_GAP, 2500, idle clk cycles enforced after a refresh completes before the next trigger (0 = no gap)
- ACK_TIMEOUT, 4, cycles to wait for lcd_busy to rise after a trigger

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  write request
- req0_row / req1_row  in  RW  target line
- req0_col / req1_col  in  CW  target column
- req0_char / req1_char  in  8  character code
- req0_ready / req1_ready  out  1  grant (combinational); write commits on the clk edge where valid&ready
- lcd_busy  in  1  driver busy (high from driver reset until its pass completes)
- lcd_trg  out  1  one-cycle refresh request to the driver
- rd_row  in  RW, rd_col  in  CW  driver read address
- rd_data  out  8  registered read data
- dirty  out  1  buffer changed since the last accepted trigger
- refresh_count  out  8  completed refreshes, wraps 255->0

## Operation
- Reset values: state CLEAR, clear index 0, req*_ready 0, lcd_trg 0, rd_data 0x00, dirty 0, refresh_count 0, RR pointer = req0.
- CLEAR: writes 0x20 to each of ROWS*COLS locations, one per cycle, in row-major order. Both readies are held 0. On the last location: dirty<=1, go to IDLE.
- Arbitration (every state except CLEAR):
  - Only one valid: it is granted.
  - Both valid: the requester not granted most recently wins.
  - The pointer updates only on a grant. At most one write per cycle.
  - Writes are accepted during every scheduler state, including an in-progress refresh.
  - col >= COLS or row >= ROWS: handshake completes, data is dropped, dirty is unchanged.
- dirty: set on any accepted in-range write. Cleared in the cycle lcd_trg=1 unless a write is accepted in that same cycle; in that case it stays 1.
- Scheduler FSM:
  - IDLE: if dirty & !lcd_busy, assert lcd_trg for one cycle and go to ACK.
  - ACK: if lcd_busy=1 within ACK_TIMEOUT cycles, go to DONE. On timeout: dirty<=1, go to IDLE (retry).
  - DONE: on lcd_busy=0, refresh_count++, load the gap counter with MIN_GAP, go to GAP, or go to IDLE if MIN_GAP=0.
  - GAP: count down to 0, then go to IDLE.
- Writes during DONE/GAP set dirty, which forces exactly one further refresh afterwards. Multiple writes do not queue multiple refreshes.
- Read port: rd_data <= buf[rd_row][rd_col] every cycle. Read-before-write: a same-cycle write to the read address returns the old value. Out-of-range address returns 0x20.

## Timing
- Grant is same-cycle. Write data is visible on rd_data 2 edges after the write edge (write edge, then read-register edge).
- CLEAR lasts ROWS*COLS cycles (64 at defaults). The first possible lcd_trg is the cycle after CLEAR ends, and only if lcd_busy=0.
- lcd_trg is high for exactly one cycle per trigger and never high outside IDLE->ACK.
- Trigger-to-trigger minimum: driver busy time + MIN_GAP + 2 cycles.
- Reset mid-operation: all state returns to reset values immediately, and CLEAR restarts from index 0. Buffer contents are undefined until CLEAR completes.

## Test plan
- Reset hold, lcd_busy=1 for 100 cycles, then release -> readies 0 for 64 cycles. Every location reads 0x20. dirty=1. lcd_trg pulses once, 1 cycle after lcd_busy falls.
- req0 and req1 both valid for 4 cycles (row 1 / col 3 'A', row 2 / col 5 'B') -> grants alternate starting with req1 after a prior req0 grant. rd_data at (1,3)=0x41 and (2,5)=0x42.
- Write accepted in the same cycle as lcd_trg -> dirty stays 1. A second trigger follows only after busy falls and MIN_GAP cycles have elapsed.
- 10 writes during DONE -> exactly one extra lcd_trg after the gap. refresh_count increments by 2 in total.
- lcd_busy never rises after lcd_trg -> after ACK_TIMEOUT=4 cycles, back in IDLE with dirty=1 and lcd_trg retried the next cycle.
- rst asserted mid-GAP -> all outputs return to reset values. CLEAR restarts and refresh_count reads 0.
